// File: rtl/pipe_scoreboard_pkg.sv
// Shared sizing and latency constants for the pipeline hazard scoreboard.
package pipe_scoreboard_pkg;

    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int LAT_W    = 3;
    localparam int CNT_W    = 32;

    localparam logic [LAT_W-1:0] LAT_ALU  = 3'd1;
    localparam logic [LAT_W-1:0] LAT_LOAD = 3'd2;
    localparam logic [LAT_W-1:0] LAT_FPU  = 3'd4;

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-stage request bundle and the scoreboard's stall/issue answer.
import pipe_scoreboard_pkg::*;

interface pipe_scoreboard_if #(
    parameter int AW    = pipe_scoreboard_pkg::AW,
    parameter int LAT_W = pipe_scoreboard_pkg::LAT_W
);
    logic             id_valid;
    logic [AW-1:0]    id_rs1;
    logic [AW-1:0]    id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_regwrite;
    logic [AW-1:0]    id_rd;
    logic [LAT_W-1:0] id_lat;
    logic             stall;
    logic             issue;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_regwrite, id_rd, id_lat,
        input  stall, issue
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_regwrite, id_rd, id_lat,
        output stall, issue
    );
endinterface

// File: rtl/pipe_scoreboard_sb_entry.sv
// One register's remaining-latency countdown; issue load beats decrement.
module pipe_scoreboard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             busy
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!hold && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// RAW/WAW hazard scoreboard beside ID: per-register countdowns, stall/issue
// decision and a stall-cycle performance counter.
import pipe_scoreboard_pkg::*;

module pipe_scoreboard #(
    parameter int NREG  = pipe_scoreboard_pkg::NREG,
    parameter int AW    = pipe_scoreboard_pkg::AW,
    parameter int LAT_W = pipe_scoreboard_pkg::LAT_W,
    parameter int CNT_W = pipe_scoreboard_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 flush,
    pipe_scoreboard_if.slave     id_bus,
    output logic [NREG-1:0]      busy_mask,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic             raw;
    logic             waw;
    logic             wr_en;
    logic [LAT_W-1:0] load_val;

    assign raw = (id_bus.id_use_rs1 && busy_mask[id_bus.id_rs1])
              || (id_bus.id_use_rs2 && busy_mask[id_bus.id_rs2]);
    assign waw = id_bus.id_regwrite && (id_bus.id_rd != '0) && busy_mask[id_bus.id_rd];

    assign id_bus.stall = id_bus.id_valid && (raw || waw);
    assign id_bus.issue = id_bus.id_valid && !id_bus.stall && !flush && !hold;

    // A latency of 0 behaves like 1: the result is forwardable next cycle.
    assign wr_en    = id_bus.issue && id_bus.id_regwrite && (id_bus.id_rd != '0);
    assign load_val = (id_bus.id_lat == '0) ? '0 : id_bus.id_lat - 1'b1;

    assign busy_mask[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        pipe_scoreboard_sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .hold     (hold),
            .load     (wr_en && (id_bus.id_rd == AW'(r))),
            .load_val (load_val),
            .busy     (busy_mask[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (id_bus.stall && !hold)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
